// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and helpers for the
// HD44780 16x2 frame writer.
package lcd_pkg;

    localparam logic [7:0] CMD_FUNC    = 8'h38;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_ROW0    = 8'h80;
    localparam logic [7:0] CMD_ROW1    = 8'hC0;

    typedef logic [3:0] state_t;

    localparam state_t ST_PWR_WAIT = 4'd0;
    localparam state_t ST_INIT     = 4'd1;
    localparam state_t ST_LOAD     = 4'd2;
    localparam state_t ST_ADDR0    = 4'd3;
    localparam state_t ST_CHARS0   = 4'd4;
    localparam state_t ST_ADDR1    = 4'd5;
    localparam state_t ST_CHARS1   = 4'd6;
    localparam state_t ST_DONE     = 4'd7;
    localparam state_t ST_IDLE     = 4'd8;

    // Character 0 sits in the top byte of the line.
    function automatic logic [7:0] char_at(
        input logic [127:0] s,
        input logic [3:0]   i
    );
        logic [127:0] t;
        t = s << {i, 3'b000};
        return t[127:120];
    endfunction

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        logic [7:0] c;
        c = CMD_FUNC;
        case (i)
            2'd0: c = CMD_FUNC;
            2'd1: c = CMD_DISP_ON;
            2'd2: c = CMD_ENTRY;
            2'd3: c = CMD_CLEAR;
            default: c = CMD_FUNC;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// One LCD bus write: SETUP, EN_CYC-wide enable pulse, then settle.
// rs/data are latched at start and held until the next write.
module lcd_write_strobe #(
    parameter int EN_CYC = 50,
    parameter int CW     = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rs,
    input  logic [7:0]    data,
    input  logic [CW-1:0] settle,
    output logic          lcd_rs,
    output logic          lcd_e,
    output logic [7:0]    lcd_data,
    output logic          done,
    output logic          idle
);

    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_PULSE  = 2'd2;
    localparam logic [1:0] PH_SETTLE = 2'd3;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] EN_LAST = CW'(EN_CYC - 1);

    logic [1:0]    phase;
    logic [CW-1:0] cnt;
    logic [CW-1:0] settle_q;

    assign lcd_e = (phase == PH_PULSE);
    assign idle  = (phase == PH_IDLE);
    assign done  = (phase == PH_SETTLE) && (cnt == settle_q - ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase    <= PH_IDLE;
            cnt      <= '0;
            settle_q <= '0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            case (phase)
                PH_IDLE: begin
                    if (start) begin
                        phase    <= PH_SETUP;
                        lcd_rs   <= rs;
                        lcd_data <= data;
                        settle_q <= settle;
                        cnt      <= '0;
                    end
                end
                PH_SETUP: phase <= PH_PULSE;
                PH_PULSE: begin
                    if (cnt == EN_LAST) begin
                        phase <= PH_SETTLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                PH_SETTLE: begin
                    if (done) begin
                        phase <= PH_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ONE;
                    end
                end
                default: phase <= PH_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_frame_writer.sv
// Power-up init and two-line redraw sequencer for a 16x2 LCD;
// redraws whenever the text changes or a refresh is requested.
module lcd_frame_writer
    import lcd_pkg::*;
#(
    parameter int PWR_CYC = 2_000_000,
    parameter int EN_CYC  = 50,
    parameter int CMD_CYC = 5_000,
    parameter int CLR_CYC = 200_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] line0,
    input  logic [127:0] line1,
    input  logic         refresh_req,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic         lcd_e,
    output logic [7:0]   lcd_data,
    output logic         busy,
    output logic         frame_done
);

    localparam int M1   = (PWR_CYC > EN_CYC) ? PWR_CYC : EN_CYC;
    localparam int M2   = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
    localparam int MAXP = (M1 > M2) ? M1 : M2;
    localparam int CW   = $clog2(MAXP + 1);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_CYC - 1);

    state_t        state;
    logic [CW-1:0] pwr_cnt;
    logic [3:0]    idx;
    logic [127:0]  shadow0;
    logic [127:0]  shadow1;
    logic          pending;
    logic          changed;

    logic          wr_state;
    logic          wr_start;
    logic          wr_rs;
    logic [7:0]    wr_byte;
    logic [CW-1:0] wr_settle;
    logic          wr_done;
    logic          wr_idle;

    assign lcd_rw     = 1'b0;
    assign frame_done = (state == ST_DONE);
    assign changed    = (line0 != shadow0) || (line1 != shadow1);

    assign wr_state = state inside {ST_INIT, ST_ADDR0, ST_CHARS0,
                                    ST_ADDR1, ST_CHARS1};
    assign wr_start = wr_state && wr_idle;

    always_comb begin
        wr_rs   = 1'b0;
        wr_byte = 8'h00;
        case (state)
            ST_INIT:   wr_byte = init_cmd(idx[1:0]);
            ST_ADDR0:  wr_byte = CMD_ROW0;
            ST_ADDR1:  wr_byte = CMD_ROW1;
            ST_CHARS0: begin
                wr_rs   = 1'b1;
                wr_byte = char_at(shadow0, idx);
            end
            ST_CHARS1: begin
                wr_rs   = 1'b1;
                wr_byte = char_at(shadow1, idx);
            end
            default: ;
        endcase
    end

    // Clear Display needs the long settle; a data byte 0x01 does not.
    assign wr_settle = (!wr_rs && wr_byte == CMD_CLEAR) ?
                       CW'(CLR_CYC) : CW'(CMD_CYC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_PWR_WAIT;
            pwr_cnt <= '0;
            idx     <= 4'd0;
            shadow0 <= '0;
            shadow1 <= '0;
            pending <= 1'b0;
            busy    <= 1'b0;
        end else begin
            busy <= 1'b1;
            if (state != ST_IDLE && state != ST_LOAD &&
                (refresh_req || changed))
                pending <= 1'b1;
            case (state)
                ST_PWR_WAIT: begin
                    if (pwr_cnt == PWR_LAST) state <= ST_INIT;
                    else pwr_cnt <= pwr_cnt + ONE;
                end
                ST_INIT: begin
                    if (wr_done) begin
                        if (idx == 4'd3) begin
                            idx   <= 4'd0;
                            state <= ST_LOAD;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_LOAD: begin
                    shadow0 <= line0;
                    shadow1 <= line1;
                    pending <= 1'b0;
                    state   <= ST_ADDR0;
                end
                ST_ADDR0: if (wr_done) state <= ST_CHARS0;
                ST_CHARS0: begin
                    if (wr_done) begin
                        if (idx == 4'd15) begin
                            idx   <= 4'd0;
                            state <= ST_ADDR1;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_ADDR1: if (wr_done) state <= ST_CHARS1;
                ST_CHARS1: begin
                    if (wr_done) begin
                        if (idx == 4'd15) begin
                            idx   <= 4'd0;
                            state <= ST_DONE;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    if (pending || changed || refresh_req) begin
                        state <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    if (changed || refresh_req) state <= ST_LOAD;
                    else busy <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    lcd_write_strobe #(
        .EN_CYC (EN_CYC),
        .CW     (CW)
    ) u_strobe (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (wr_start),
        .rs       (wr_rs),
        .data     (wr_byte),
        .settle   (wr_settle),
        .lcd_rs   (lcd_rs),
        .lcd_e    (lcd_e),
        .lcd_data (lcd_data),
        .done     (wr_done),
        .idle     (wr_idle)
    );

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: bus monitor plus a frame-level
// byte-sequence model driven by table and random text updates.
module tb_lcd_frame_writer;

    localparam int PWR = 10;
    localparam int EN  = 2;
    localparam int CMD = 4;
    localparam int CLR = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] line0;
    logic [127:0] line1;
    logic         refresh_req = 1'b0;
    logic         lcd_rs;
    logic         lcd_rw;
    logic         lcd_e;
    logic [7:0]   lcd_data;
    logic         busy;
    logic         frame_done;

    always #5 clk = ~clk;

    lcd_frame_writer #(
        .PWR_CYC (PWR),
        .EN_CYC  (EN),
        .CMD_CYC (CMD),
        .CLR_CYC (CLR)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .line0       (line0),
        .line1       (line1),
        .refresh_req (refresh_req),
        .lcd_rs      (lcd_rs),
        .lcd_rw      (lcd_rw),
        .lcd_e       (lcd_e),
        .lcd_data    (lcd_data),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_ge(input string nm, input int act, input int min);
        n_chk++;
        if (act < min) begin
            n_fail++;
            $display("FAIL %s: got %0d, required >= %0d", nm, act, min);
        end
    endtask

    // Bus monitor: captures {rs,data} per enable pulse and checks timing.
    logic [8:0] cap[$];
    int         fd_count = 0;
    int         first_rise = 0;

    initial begin
        logic       prev_e;
        logic       have_prev;
        logic [8:0] held;
        int         pw;
        int         fall_cyc;
        int         req_settle;
        int         hold_left;
        prev_e = 0; have_prev = 0; held = '0;
        pw = 0; fall_cyc = 0; req_settle = CMD; hold_left = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_e = 0; have_prev = 0; hold_left = 0;
            end else begin
                if (frame_done) begin
                    fd_count++;
                    check_ge("frame_done_settle", cyc - fall_cyc, CMD);
                end
                if (!busy && !lcd_e) have_prev = 0;
                if (lcd_e && !prev_e) begin
                    if (have_prev)
                        check_ge("settle_gap", cyc - fall_cyc, req_settle + 1);
                    if (cap.size() == 0) first_rise = cyc;
                    held = {lcd_rs, lcd_data};
                    cap.push_back(held);
                    pw = 1;
                    hold_left = 0;
                    req_settle = (!lcd_rs && lcd_data == 8'h01) ? CLR : CMD;
                end else if (lcd_e && prev_e) begin
                    pw++;
                    check("hold_pulse", {lcd_rs, lcd_data}, held);
                end else if (!lcd_e && prev_e) begin
                    check("e_width", pw, EN);
                    check("hold_settle", {lcd_rs, lcd_data}, held);
                    fall_cyc = cyc;
                    have_prev = 1;
                    hold_left = req_settle - 1;
                end else if (hold_left > 0) begin
                    check("hold_settle", {lcd_rs, lcd_data}, held);
                    hold_left--;
                end
                prev_e = lcd_e;
            end
        end
    end

    // Reference model: frame = optional init cmds, row0 addr, 16 chars,
    // row1 addr, 16 chars.
    logic [8:0] exp_q[$];

    function automatic void push_frame(input logic [127:0] a,
                                       input logic [127:0] b,
                                       input bit with_init);
        logic [7:0] ic[4];
        ic = '{8'h38, 8'h0C, 8'h06, 8'h01};
        if (with_init)
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, ic[i]});
        exp_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, a[127-8*i -: 8]});
        exp_q.push_back({1'b0, 8'hC0});
        for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, b[127-8*i -: 8]});
    endfunction

    task automatic cmp_writes(input string nm);
        check($sformatf("%s_len", nm), cap.size(), exp_q.size());
        for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
            check($sformatf("%s[%0d]", nm, i), cap[i], exp_q[i]);
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int n;
        n = 0;
        repeat (3) @(negedge clk);
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_idle"}, busy, 1'b0);
    endtask

    task automatic wait_caps(input string nm, input int k, input int maxc);
        int n;
        n = 0;
        while (cap.size() < k && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check_ge(nm, cap.size(), k);
    endtask

    task automatic apply(input logic [127:0] a, input logic [127:0] b,
                         input bit rf);
        @(negedge clk);
        line0 = a;
        line1 = b;
        refresh_req = rf;
        @(negedge clk);
        refresh_req = 1'b0;
    endtask

    typedef struct {
        logic [127:0] l0;
        logic [127:0] l1;
        bit           rf;
        int           nframes;
    } vec_t;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[4];
        int           rel;
        int           bh;
        int           nf;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] old1;

        tbl[0] = '{"Wrong pass!     ", "    to open     ", 1'b0, 1};
        tbl[1] = '{"Wrong pass!     ", "    to open     ", 1'b1, 1};
        tbl[2] = '{"Locked          ", "    to open     ", 1'b1, 1};
        tbl[3] = '{"Locked          ", "Try again       ", 1'b0, 1};

        line0 = "Enter password  ";
        line1 = "    to open     ";
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_lcd_e", lcd_e, 1'b0);
        check("rst_lcd_rs", lcd_rs, 1'b0);
        check("rst_lcd_rw", lcd_rw, 1'b0);
        check("rst_lcd_data", lcd_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);

        cap.delete();
        fd_count = 0;
        rst_n = 1'b1;
        rel = cyc;
        @(negedge clk);
        check("busy_after_release", busy, 1'b1);
        wait_idle("frame1", 3000);
        check_ge("pwr_wait", first_rise - rel, PWR + 1);
        exp_q.delete();
        push_frame(line0, line1, 1);
        cmp_writes("frame1");
        check("frame1_done_count", fd_count, 1);

        cap.delete();
        fd_count = 0;
        bh = 0;
        repeat (500) begin
            @(negedge clk);
            if (busy || lcd_e) bh++;
        end
        check("idle_writes", cap.size(), 0);
        check("idle_busy_cycles", bh, 0);
        check("idle_frames", fd_count, 0);

        for (int i = 0; i < 4; i++) begin
            cap.delete();
            fd_count = 0;
            exp_q.delete();
            for (int f = 0; f < tbl[i].nframes; f++)
                push_frame(tbl[i].l0, tbl[i].l1, 0);
            apply(tbl[i].l0, tbl[i].l1, tbl[i].rf);
            wait_idle($sformatf("vec%0d", i), 3000);
            cmp_writes($sformatf("vec%0d", i));
            check($sformatf("vec%0d_frames", i), fd_count, tbl[i].nframes);
        end

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 16; k++) begin
                a[8*k +: 8] = 8'($urandom_range(126, 32));
                b[8*k +: 8] = 8'($urandom_range(126, 32));
            end
            if (r == 3) a = line0;
            nf = ((a != line0) || (b != line1)) ? 1 : 0;
            cap.delete();
            fd_count = 0;
            exp_q.delete();
            if (nf == 1) push_frame(a, b, 0);
            apply(a, b, 1'b0);
            wait_idle($sformatf("rnd%0d", r), 3000);
            cmp_writes($sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_frames", r), fd_count, nf);
        end

        cap.delete();
        fd_count = 0;
        old1 = line1;
        a = "Mid-frame test  ";
        apply(a, old1, 1'b0);
        wait_caps("mid_reach_chars0", 6, 1000);
        line1 = "First change    ";
        repeat (3) @(negedge clk);
        line1 = "Final text      ";
        wait_idle("midframe", 5000);
        exp_q.delete();
        push_frame(a, old1, 0);
        push_frame(a, "Final text      ", 0);
        cmp_writes("midframe");
        check("midframe_frames", fd_count, 2);

        cap.delete();
        fd_count = 0;
        apply(line0, line1, 1'b1);
        bh = 0;
        while (!(cap.size() >= 10 && lcd_e) && bh < 2000) begin
            @(negedge clk);
            bh++;
        end
        check("rst_mid_in_pulse", lcd_e, 1'b1);
        check("rst_mid_is_data", cap[cap.size()-1][8], 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_lcd_e", lcd_e, 1'b0);
        check("rst_mid_lcd_rs", lcd_rs, 1'b0);
        check("rst_mid_lcd_data", lcd_data, 8'h00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_frame_done", frame_done, 1'b0);
        repeat (2) @(negedge clk);
        cap.delete();
        fd_count = 0;
        rst_n = 1'b1;
        rel = cyc;
        wait_idle("rst_frame", 3000);
        check_ge("rst_pwr_wait", first_rise - rel, PWR + 1);
        exp_q.delete();
        push_frame(line0, line1, 1);
        cmp_writes("rst_frame");
        check("rst_frame_count", fd_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_frame_writer.md
Name: lcd_frame_writer

Overview:
- Sequences a 16x2 HD44780-compatible character LCD in 8-bit parallel mode.
- Takes two 128-bit line strings (16 ASCII chars each, first char in bits [127:120]) from the message generator, runs power-up init, then streams both lines to the panel.
- Refreshes the panel whenever the input text changes.
- Sits between the per-state message mux and the board LCD pins.

Parameters:
- PWR_CYC, 2_000_000: clock cycles to wait after reset before the first command (at least 15 ms at board clock).
- EN_CYC, 50: clock cycles lcd_e is held high per write.
- CMD_CYC, 5_000: settle cycles after a normal command/data write (at least 40 us).
- CLR_CYC, 200_000: settle cycles after the Clear Display command (at least 1.64 ms).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- line0  in  128  top-row text, char0 = [127:120]
- line1  in  128  bottom-row text, char0 = [127:120]
- refresh_req  in  1  single-cycle pulse that forces a redraw even if text is unchanged
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- lcd_e  out  1  enable strobe
- lcd_data  out  8  data bus
- busy  out  1  high from reset until the end of the current frame
- frame_done  out  1  one-cycle pulse when a frame's last settle period ends

Behaviour:
- Reset (rst_n=0 sampled on clk):
  - All outputs are 0; lcd_data=8'h00.
  - busy=1 as soon as rst_n is released.
  - State=PWR_WAIT; snapshot registers and pending flag are cleared.
  - Reset mid-write aborts immediately; lcd_e drops in the same cycle as the reset edge.
- Write primitive (one command or data byte), total 1+EN_CYC+settle cycles:
  - SETUP: 1 cycle, rs/data driven, e=0.
  - PULSE: EN_CYC cycles, e=1.
  - SETTLE: CMD_CYC cycles, or CLR_CYC if the byte is command 8'h01; e=0.
  - rs and data hold stable from SETUP through the end of SETTLE.
- States:
  - PWR_WAIT: count PWR_CYC, then go to INIT.
  - INIT: four commands in order: 8'h38 (function set), 8'h0C (display on), 8'h06 (entry mode), 8'h01 (clear). Then go to LOAD.
  - LOAD: snapshot line0/line1 into shadow registers, clear pending, go to ADDR0.
  - ADDR0: command 8'h80. CHARS0: 16 data writes, bytes [127:120] down to [7:0] of shadow0.
  - ADDR1: command 8'hC0. CHARS1: 16 data writes from shadow1.
  - DONE: pulse frame_done for 1 cycle. If pending=1, go to LOAD; otherwise go to IDLE and drop busy.
  - IDLE: busy=0. If (line0,line1) != shadow or refresh_req=1, go to LOAD and set busy=1 on the next cycle.
- Frame length: 34 writes. The first frame after reset follows INIT directly.
- Text change or refresh_req during any non-IDLE state sets pending; shadow is not altered mid-frame.
  - At DONE, a redraw starts if pending=1 or inputs != shadow.
  - Multiple changes in one frame yield exactly one extra frame.
- refresh_req and a text change in the same IDLE cycle produce one frame.
- Character index counter is 0..15; wrap is never observed because the state changes at index 15.
- Cycle counters are sized to the largest parameter plus 1. No other arithmetic.

Decomposition:
- Shared package lcd_pkg holds:
  - LCD command constants: CMD_FUNC=8'h38, CMD_DISP_ON=8'h0C, CMD_ENTRY=8'h06, CMD_CLEAR=8'h01, CMD_ROW0=8'h80, CMD_ROW1=8'hC0.
  - The controller state enum.
- One natural sub-module, lcd_write_strobe:
  - Takes start, rs, data, and a settle count.
  - Drives the SETUP/PULSE/SETTLE timing and returns a one-cycle done.
  - The top FSM sequences bytes only.

Test Plan (bench uses PWR_CYC=10, EN_CYC=2, CMD_CYC=4, CLR_CYC=8):
- Reset, lines "Enter password  " / "    to open     " -> no lcd_e for 10 cycles, then 38,0C,06,01 with rs=0, 80, 16 data bytes starting 0x45, C0, 16 data bytes starting 0x20. Each e pulse is 2 cycles wide. Settle is 4 cycles after every write except 01, which gets 8. frame_done fires once, then busy=0.
- Idle with unchanged lines for 500 cycles -> no lcd_e activity, busy stays 0.
- Change line0 to "Wrong pass!     " in IDLE -> new frame with no INIT: 80, 'W'(0x57)... then C0. frame_done again.
- Change line1 twice during CHARS0 -> current frame completes with the old text, then exactly one extra frame with the final text.
- refresh_req pulse in IDLE with unchanged text -> one full 34-write frame with identical bytes.
- Assert rst_n=0 during the PULSE of a data write -> lcd_e=0 and all outputs 0 next cycle. After release, the full PWR_WAIT+INIT sequence repeats.
